jesd204_scrambler_multilane: RTL
================================

JESD204_SCRAMBLER_MULTILANE -- requirements
Module: jesd204_scrambler_multilane

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independent lanes, 1..32.
REQ-002 Parameter DATA_PATH_WIDTH, default 4: bytes per lane per beat, 1..8.
REQ-003 Parameter DESCRAMBLE, default 0: 0 = scrambler, 1 = descrambler.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port lane_enable, input, NUM_LANES: per lane, 1 = scramble/descramble, 0 = pass-through.
REQ-007 Port in_valid, input, 1: in_data holds a beat this cycle.
REQ-008 Port in_data, input, NUM_LANES*DATA_PATH_WIDTH*8: lane L occupies bits [L*W+W-1:L*W], W = DATA_PATH_WIDTH*8; byte 0 is earliest on the wire.
REQ-009 Port seed_load, input, 1: load seed_value into all lane LFSRs.
REQ-010 Port seed_value, input, 15: LFSR load value.
REQ-011 Port out_valid, output, 1: out_data holds a processed beat.
REQ-012 Port out_data, output, NUM_LANES*DATA_PATH_WIDTH*8: same lane/byte layout as in_data.
REQ-013 Port lane_synced, output, NUM_LANES: per-lane LFSR history valid.

Function
REQ-014 Polynomial 1+x^14+x^15 shall be used; within a byte, bit 7 is the earliest bit; bytes are processed in ascending order.
REQ-015 Per-lane 15-bit state: bit 14 = oldest (s[n-15]), bit 0 = newest (s[n-1]).
REQ-016 Scrambler: s[n] = d[n] ^ s[n-14] ^ s[n-15]; state shifts in s.
REQ-017 Descrambler: d[n] = s[n] ^ s[n-14] ^ s[n-15]; state shifts in received s.
REQ-018 Each lane processes DATA_PATH_WIDTH*8 bits per beat combinationally; no multi-cycle iteration.
REQ-019 State advances only on beats with in_valid=1; without in_valid, state holds.
REQ-020 State advances regardless of lane_enable; a disabled lane outputs in_data unmodified.
REQ-021 Latency: exactly one cycle; out_valid(t+1)=in_valid(t); out_data is registered.
REQ-022 out_data holds its last value when out_valid=0.
REQ-023 No backpressure; a beat is accepted every cycle in_valid=1.
REQ-024 On seed_load=1 with in_valid=1, the beat uses the old state; state then becomes seed_value.
REQ-025 seed_load clears every lane's sync counter.
REQ-026 Descrambler: per-lane counter of valid bytes, saturating at 2; lane_synced=1 once the count reaches 2 (after beat 1 if DATA_PATH_WIDTH>=2, else after beat 2).
REQ-027 Scrambler: lane_synced=all-ones from the first cycle after reset deasserts, and stays set through seed_load.
REQ-028 Output bytes before lane_synced=1 in descramble mode are undefined but still flagged by out_valid.

Reset
REQ-029 Reset sets all lane states to 15'h7f80, out_valid=0, out_data=0, lane_synced=0, and sync counters=0.
REQ-030 Reset overrides seed_load and in_valid in the same cycle; a beat in flight is dropped (out_valid=0 next cycle).

Structure
REQ-031 The shared jesd204 package shall hold the constants LFSR_WIDTH=15, LFSR_RESET_SEED=15'h7f80, and SYNC_BYTES=2.
REQ-032 Per-lane datapath (state, feedback, sync counter) shall be the sub-module jesd204_scrambler_lane, instantiated NUM_LANES times; the top shall hold the valid/output registers.

Verification
REQ-033 Scrambler, reset seed, lane 0 in_data all-zero, enable=1 -> first output byte 0x01; loopback through DESCRAMBLE=1 instance returns all-zero.
REQ-034 Random data, 1000 beats, in_valid toggled randomly, scrambler->descrambler chain -> descrambler output equals input once lane_synced=1; out_valid is in_valid delayed 1 cycle.
REQ-035 lane_enable=4'b0101 -> lanes 1 and 3 bit-exact pass-through; lanes 0 and 2 match the reference model.
REQ-036 seed_load=1 with seed_value=15'h0000 plus in_valid, all-zero data -> that beat uses the old state; all following outputs are zero (zero LFSR fixed point).
REQ-037 Descrambler DATA_PATH_WIDTH=1 -> lane_synced rises after the 2nd valid beat; seed_load mid-stream drops it to 0 for 2 beats.
REQ-038 Reset asserted mid-stream -> next cycle out_valid=0, out_data=0, lane_synced=0; the first post-reset beat matches the 15'h7f80 seed model.

Source files
------------

// File: rtl/jesd204_pkg.sv
// Shared constants and helpers for the JESD204 self-synchronous
// scrambler/descrambler (polynomial 1 + x^14 + x^15).
package jesd204_pkg;

    localparam int LFSR_WIDTH = 15;
    localparam int SYNC_BYTES = 2;
    localparam int SYNC_CNT_WIDTH = $clog2(SYNC_BYTES + 1);

    typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

    localparam lfsr_state_t LFSR_RESET_SEED = 15'h7f80;
    localparam logic [SYNC_CNT_WIDTH-1:0] SYNC_CNT_MAX = SYNC_CNT_WIDTH'(SYNC_BYTES);

    typedef enum logic {
        MODE_SCRAMBLE   = 1'b0,
        MODE_DESCRAMBLE = 1'b1
    } scr_mode_e;

    // State bit 14 holds s[n-15] and bit 13 holds s[n-14].
    function automatic logic lfsr_feedback(input lfsr_state_t state);
        return state[LFSR_WIDTH-1] ^ state[LFSR_WIDTH-2];
    endfunction

endpackage

// File: rtl/jesd204_scrambler_lane.sv
// One lane of the scrambler/descrambler: LFSR history, a full beat of
// combinational bit-serial feedback, and the descrambler sync counter.
module jesd204_scrambler_lane
    import jesd204_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int DESCRAMBLE      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic [DATA_PATH_WIDTH*8-1:0] in_data,
    input  logic                         seed_load,
    input  logic [LFSR_WIDTH-1:0]        seed_value,
    output logic [DATA_PATH_WIDTH*8-1:0] out_data,
    output logic                         synced
);

    localparam int W = DATA_PATH_WIDTH * 8;
    localparam scr_mode_e MODE = (DESCRAMBLE != 0) ? MODE_DESCRAMBLE : MODE_SCRAMBLE;

    lfsr_state_t               state_q, state_d;
    logic [SYNC_CNT_WIDTH-1:0] sync_cnt_q, sync_cnt_d;
    logic                      synced_q, synced_d;

    lfsr_state_t state_walk;
    logic [W-1:0] coded;
    logic         line_bit;

    // NOTE: blocking assignments are intentional here; state_walk carries the
    // LFSR through every bit of the beat within a single evaluation.
    always_comb begin
        state_walk = state_q;
        coded      = '0;
        line_bit   = 1'b0;
        for (int b = 0; b < DATA_PATH_WIDTH; b++) begin
            for (int i = 7; i >= 0; i--) begin
                coded[b*8+i] = in_data[b*8+i] ^ lfsr_feedback(state_walk);
                // The history always holds line (scrambled) bits in both modes.
                line_bit     = (MODE == MODE_DESCRAMBLE) ? in_data[b*8+i] : coded[b*8+i];
                state_walk   = {state_walk[LFSR_WIDTH-2:0], line_bit};
            end
        end
    end

    assign out_data = enable ? coded : in_data;

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        if (seed_load) begin
            state_d    = seed_value;
            sync_cnt_d = '0;
        end else if (in_valid) begin
            state_d = state_walk;
            if (32'(sync_cnt_q) + DATA_PATH_WIDTH >= SYNC_BYTES) begin
                sync_cnt_d = SYNC_CNT_MAX;
            end else begin
                sync_cnt_d = sync_cnt_q + SYNC_CNT_WIDTH'(1);
            end
        end
        synced_d = (MODE == MODE_DESCRAMBLE) ? (sync_cnt_d == SYNC_CNT_MAX) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LFSR_RESET_SEED;
            sync_cnt_q <= '0;
            synced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            synced_q   <= synced_d;
        end
    end

    assign synced = synced_q;

endmodule

// File: rtl/jesd204_scrambler_multilane.sv
// Multi-lane JESD204 scrambler/descrambler: independent per-lane LFSRs with a
// shared registered output stage of one-cycle latency.
module jesd204_scrambler_multilane
    import jesd204_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int DESCRAMBLE      = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_LANES-1:0]                   lane_enable,
    input  logic                                   in_valid,
    input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] in_data,
    input  logic                                   seed_load,
    input  logic [LFSR_WIDTH-1:0]                  seed_value,
    output logic                                   out_valid,
    output logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] out_data,
    output logic [NUM_LANES-1:0]                   lane_synced
);

    localparam int W     = DATA_PATH_WIDTH * 8;
    localparam int BUS_W = NUM_LANES * W;

    logic [BUS_W-1:0] lane_data;
    logic [BUS_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        jesd204_scrambler_lane #(
            .DATA_PATH_WIDTH (DATA_PATH_WIDTH),
            .DESCRAMBLE      (DESCRAMBLE)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .enable     (lane_enable[l]),
            .in_valid   (in_valid),
            .in_data    (in_data[l*W +: W]),
            .seed_load  (seed_load),
            .seed_value (seed_value),
            .out_data   (lane_data[l*W +: W]),
            .synced     (lane_synced[l])
        );
    end

    // Output data is held across idle cycles so downstream sees a stable bus.
    always_comb begin
        out_valid_d = in_valid;
        out_data_d  = out_data_q;
        if (in_valid) begin
            out_data_d = lane_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
